// File: rtl/usr_sw_pkg.sv
// Shared sizing constants for the front-panel switch reader.
// Glitch-counter width and saturation value live here so top and bench agree.
package usr_sw_pkg;
  localparam int USR_SW_W            = 8;
  localparam int USR_SW_DEBOUNCE_DEF = 1000000;
  localparam int GLITCH_CNT_W        = 16;
  localparam logic [GLITCH_CNT_W-1:0] GLITCH_SAT = 16'hFFFF;
endpackage

// File: rtl/usr_sw_debounce_bit.sv
// One switch bit: 2-flop synchroniser, debounce counter, stable state.
// chg_o pulses for one cycle alongside the stable flip; glitch_o flags an aborted count.
module usr_sw_debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic sys0_clk,
  input  logic sys0_rst,
  input  logic raw_i,
  output logic stable_o,
  output logic chg_o,
  output logic glitch_o
);
  logic             meta_q, sync_q;
  logic             stable_q, stable_d;
  logic             chg_q, chg_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_ff @(posedge sys0_clk or posedge sys0_rst) begin
    if (sys0_rst) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      stable_q <= 1'b0;
      chg_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      meta_q   <= raw_i;
      sync_q   <= meta_q;
      stable_q <= stable_d;
      chg_q    <= chg_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    stable_d = stable_q;
    chg_d    = 1'b0;
    cnt_d    = cnt_q;
    glitch_o = 1'b0;
    if (sync_q != stable_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
        stable_d = sync_q;
        chg_d    = 1'b1;
        cnt_d    = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end else begin
      // Input went back before the count completed: a rejected bounce.
      cnt_d    = '0;
      glitch_o = (cnt_q != '0);
    end
  end

  assign stable_o = stable_q;
  assign chg_o    = chg_q;
endmodule

// File: rtl/usr_sw_reader.sv
// Debounced DIP-switch bank presented as a valid/ready change-event stream.
// Optional rejected-bounce counter enabled by defining USR_SW_GLITCH_CNT_EN.
module usr_sw_reader
  import usr_sw_pkg::*;
#(
  parameter int WIDTH           = USR_SW_W,
  parameter int DEBOUNCE_CYCLES = USR_SW_DEBOUNCE_DEF,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic                    sys0_clk,
  input  logic                    sys0_rst,
  input  logic [WIDTH-1:0]        usr_sw,
  output logic [WIDTH-1:0]        sw_state,
  output logic                    evt_valid,
  input  logic                    evt_ready,
  output logic [WIDTH-1:0]        evt_mask,
  output logic [WIDTH-1:0]        evt_state,
  output logic                    evt_ovf,
  input  logic                    glitch_clr,
  output logic [GLITCH_CNT_W-1:0] glitch_cnt
);
  logic [WIDTH-1:0] chg, glitch;

  for (genvar g = 0; g < WIDTH; g++) begin : g_bit
    usr_sw_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .CNT_W          (CNT_W)
    ) u_bit (
      .sys0_clk(sys0_clk),
      .sys0_rst(sys0_rst),
      .raw_i   (usr_sw[g]),
      .stable_o(sw_state[g]),
      .chg_o   (chg[g]),
      .glitch_o(glitch[g])
    );
  end

  logic             evt_valid_q, evt_valid_d;
  logic [WIDTH-1:0] evt_mask_q, evt_mask_d;
  logic [WIDTH-1:0] evt_state_q, evt_state_d;
  logic             evt_ovf_q, evt_ovf_d;
  logic [WIDTH-1:0] pend_mask_q, pend_mask_d;
  logic             pend_ovf_q, pend_ovf_d;
  logic [WIDTH-1:0] new_mask;
  logic             hit;

  always_ff @(posedge sys0_clk or posedge sys0_rst) begin
    if (sys0_rst) begin
      evt_valid_q <= 1'b0;
      evt_mask_q  <= '0;
      evt_state_q <= '0;
      evt_ovf_q   <= 1'b0;
      pend_mask_q <= '0;
      pend_ovf_q  <= 1'b0;
    end else begin
      evt_valid_q <= evt_valid_d;
      evt_mask_q  <= evt_mask_d;
      evt_state_q <= evt_state_d;
      evt_ovf_q   <= evt_ovf_d;
      pend_mask_q <= pend_mask_d;
      pend_ovf_q  <= pend_ovf_d;
    end
  end

  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_mask_d  = evt_mask_q;
    evt_state_d = evt_state_q;
    evt_ovf_d   = evt_ovf_q;
    pend_mask_d = pend_mask_q;
    pend_ovf_d  = pend_ovf_q;
    new_mask    = pend_mask_q | chg;
    hit         = ((chg & pend_mask_q) != '0);
    // Output slot is free or being drained this edge: fold in this cycle's chg too.
    if (!evt_valid_q || evt_ready) begin
      if (new_mask != '0) begin
        evt_valid_d = 1'b1;
        evt_mask_d  = new_mask;
        evt_state_d = sw_state;
        evt_ovf_d   = pend_ovf_q | hit;
        pend_mask_d = '0;
        pend_ovf_d  = 1'b0;
      end else begin
        evt_valid_d = 1'b0;
      end
    end else begin
      pend_mask_d = new_mask;
      pend_ovf_d  = pend_ovf_q | hit;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_mask  = evt_mask_q;
  assign evt_state = evt_state_q;
  assign evt_ovf   = evt_ovf_q;

`ifdef USR_SW_GLITCH_CNT_EN
  logic [GLITCH_CNT_W-1:0] gcnt_q, gcnt_d;
  logic [GLITCH_CNT_W:0]   gsum;

  always_ff @(posedge sys0_clk or posedge sys0_rst) begin
    if (sys0_rst) gcnt_q <= '0;
    else          gcnt_q <= gcnt_d;
  end

  always_comb begin
    gsum = {1'b0, gcnt_q};
    for (int i = 0; i < WIDTH; i++) gsum = gsum + (GLITCH_CNT_W+1)'(glitch[i]);
    if (glitch_clr)                   gcnt_d = '0;
    else if (gsum > {1'b0, GLITCH_SAT}) gcnt_d = GLITCH_SAT;
    else                              gcnt_d = gsum[GLITCH_CNT_W-1:0];
  end

  assign glitch_cnt = gcnt_q;
`else
  logic unused_glitch;
  assign unused_glitch = glitch_clr ^ (^glitch);
  assign glitch_cnt    = '0;
`endif
endmodule

// File: tb/tb_usr_sw_reader.sv
// Directed bench for usr_sw_reader with DEBOUNCE_CYCLES=4, WIDTH=8.
module tb_usr_sw_reader;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  usr_sw = 8'h00;
  logic        evt_ready = 1'b0;
  logic        glitch_clr = 1'b0;
  logic [7:0]  sw_state, evt_mask, evt_state;
  logic        evt_valid, evt_ovf;
  logic [15:0] glitch_cnt;
  int checks = 0;
  int failures = 0;
  logic seen_evt;

  always #5 clk = ~clk;

  usr_sw_reader #(.WIDTH(8), .DEBOUNCE_CYCLES(4)) dut (
    .sys0_clk  (clk),
    .sys0_rst  (rst),
    .usr_sw    (usr_sw),
    .sw_state  (sw_state),
    .evt_valid (evt_valid),
    .evt_ready (evt_ready),
    .evt_mask  (evt_mask),
    .evt_state (evt_state),
    .evt_ovf   (evt_ovf),
    .glitch_clr(glitch_clr),
    .glitch_cnt(glitch_cnt)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_evt(input string tag, input logic v, input logic [7:0] m,
                         input logic [7:0] s, input logic o);
    chk({tag, "_valid"}, 16'(evt_valid), 16'(v));
    chk({tag, "_mask"},  16'(evt_mask),  16'(m));
    chk({tag, "_state"}, 16'(evt_state), 16'(s));
    chk({tag, "_ovf"},   16'(evt_ovf),   16'(o));
  endtask

  initial begin
    // 1: async reset with all switches high, release and count edges
    usr_sw = 8'hFF;
    #1 rst = 1'b1;
    #1;
    chk("rst_sw_state", 16'(sw_state), 16'h0);
    chk_evt("rst_evt", 1'b0, 8'h00, 8'h00, 1'b0);
    chk("rst_glitch", glitch_cnt, 16'h0);
    tick(2);
    rst = 1'b0;
    tick(5);
    chk("t1_edge5", 16'(sw_state), 16'h00);
    tick(1);
    chk("t1_edge6", 16'(sw_state), 16'hFF);
    tick(1);
    chk_evt("t1_evt", 1'b1, 8'hFF, 8'hFF, 1'b0);
    rst = 1'b1;
    usr_sw = 8'h00;
    #1;
    chk("t1_async_valid", 16'(evt_valid), 16'h0);
    chk("t1_async_state", 16'(sw_state), 16'h0);
    tick(2);
    rst = 1'b0;
    tick(10);
    chk_evt("t1_idle", 1'b0, 8'h00, 8'h00, 1'b0);

    // 2: single bit rise, consumer always ready
    evt_ready = 1'b1;
    usr_sw = 8'h01;
    tick(5);
    chk("t2_edge5", 16'(sw_state), 16'h00);
    tick(1);
    chk("t2_edge6", 16'(sw_state), 16'h01);
    chk("t2_edge6_valid", 16'(evt_valid), 16'h0);
    tick(1);
    chk_evt("t2_edge7", 1'b1, 8'h01, 8'h01, 1'b0);
    tick(1);
    chk("t2_edge8_valid", 16'(evt_valid), 16'h0);

    // 3: bit3 bounce for 3 cycles
    usr_sw = 8'h09;
    tick(3);
    usr_sw = 8'h01;
    tick(8);
    chk("t3_sw_state", 16'(sw_state), 16'h01);
    chk("t3_no_evt", 16'(evt_valid), 16'h0);
`ifdef USR_SW_GLITCH_CNT_EN
    chk("t3_glitch", glitch_cnt, 16'h1);
`else
    chk("t3_glitch", glitch_cnt, 16'h0);
`endif

    // 4: held event, second change queued until accept
    usr_sw = 8'h00;
    tick(10);
    chk("t4_pre_state", 16'(sw_state), 16'h00);
    evt_ready = 1'b0;
    usr_sw = 8'h01;
    tick(7);
    chk_evt("t4_first", 1'b1, 8'h01, 8'h01, 1'b0);
    usr_sw = 8'h03;
    tick(8);
    chk("t4_sw_state", 16'(sw_state), 16'h03);
    chk_evt("t4_held", 1'b1, 8'h01, 8'h01, 1'b0);
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    chk_evt("t4_second", 1'b1, 8'h02, 8'h03, 1'b0);
    tick(3);
    chk("t4_second_held", 16'(evt_mask), 16'h02);

    // 5: bit0 toggles repeatedly while an event is held -> overflow
    evt_ready = 1'b1;
    usr_sw = 8'h00;
    tick(10);
    chk("t5_drained", 16'(evt_valid), 16'h0);
    evt_ready = 1'b0;
    usr_sw = 8'h01;
    tick(8);
    usr_sw = 8'h00;
    tick(8);
    usr_sw = 8'h01;
    tick(8);
    usr_sw = 8'h00;
    tick(8);
    chk("t5_sw_state", 16'(sw_state), 16'h00);
    chk_evt("t5_held", 1'b1, 8'h01, 8'h01, 1'b0);
    evt_ready = 1'b1;
    tick(1);
    evt_ready = 1'b0;
    chk_evt("t5_ovf_evt", 1'b1, 8'h01, 8'h00, 1'b1);
    evt_ready = 1'b1;
    tick(1);
    chk("t5_empty", 16'(evt_valid), 16'h0);

    // 6: reset in the middle of a debounce count
    usr_sw = 8'h01;
    tick(10);
    chk("t6_pre_state", 16'(sw_state), 16'h01);
    usr_sw = 8'h00;
    tick(4);
    rst = 1'b1;
    #1;
    chk("t6_async_state", 16'(sw_state), 16'h00);
    tick(2);
    rst = 1'b0;
    seen_evt = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tick(1);
      if (evt_valid !== 1'b0) seen_evt = 1'b1;
    end
    chk("t6_no_evt", 16'(seen_evt), 16'h0);
    chk("t6_sw_state", 16'(sw_state), 16'h00);

    // glitch storm on all bits to saturate the counter
    for (int i = 0; i < 8250; i++) begin
      usr_sw = 8'hFF;
      tick(1);
      usr_sw = 8'h00;
      tick(1);
    end
    tick(10);
    chk("storm_sw_state", 16'(sw_state), 16'h00);
    chk("storm_no_evt", 16'(evt_valid), 16'h0);
`ifdef USR_SW_GLITCH_CNT_EN
    chk("storm_sat", glitch_cnt, 16'hFFFF);
`else
    chk("storm_sat", glitch_cnt, 16'h0000);
`endif
    // clear lands on the same edge as a bit3 glitch
    usr_sw = 8'h08;
    tick(1);
    usr_sw = 8'h00;
    tick(2);
    glitch_clr = 1'b1;
    tick(1);
    glitch_clr = 1'b0;
    chk("clr_priority", glitch_cnt, 16'h0);
    usr_sw = 8'h08;
    tick(1);
    usr_sw = 8'h00;
    tick(5);
`ifdef USR_SW_GLITCH_CNT_EN
    chk("post_clr_count", glitch_cnt, 16'h1);
`else
    chk("post_clr_count", glitch_cnt, 16'h0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
